// File: rtl/dropoff_station_scheduler.sv
// Dropoff station scheduler: per-channel network contribution and train limit, one channel per 4-state pass.
// Optional build macro DROPOFF_SLEW_LIMIT_EN limits each l_bus slice to a step of 1 per evaluation.
//
// state | meaning
// IDLE  | waiting for in_valid; inputs captured on handshake
// ST_A  | buffered-plus-train units a for channel k
// ST_S  | contribution s and network share v
// ST_D  | headroom h and demand n
// ST_L  | limit l; write slice k of s_bus / l_bus
// DONE  | out_valid pulse
module dropoff_station_scheduler #(
    parameter int CH  = 2,
    parameter int INT = 31,
    parameter int Q   = 3,
    parameter int M   = 128000,
    parameter int W   = 8000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INT:0]          p,
    input  logic [INT:0]          g,
    input  logic [INT:0]          r,
    input  logic [CH*(INT+1)-1:0] u_bus,
    input  logic [CH*(INT+1)-1:0] c_bus,
    input  logic [CH*(INT+1)-1:0] t_bus,
    output logic [CH*(INT+1)-1:0] s_bus,
    output logic [CH*(INT+1)-1:0] l_bus,
    output logic                  out_valid
);
    localparam int WD = INT + 1;
    localparam int WW = 2 * WD;
    localparam int KW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic signed [WD-1:0] ONE = WD'(1);
    localparam logic signed [WD-1:0] Q_N = WD'(Q);
    localparam logic signed [WD-1:0] M_N = WD'(M);
    localparam logic signed [WD-1:0] W_N = WD'(W);
    localparam logic signed [WW-1:0] M_W = WW'(M);
    localparam logic signed [WW-1:0] W_W = WW'(W);

    typedef enum logic [2:0] {IDLE, ST_A, ST_S, ST_D, ST_L, DONE} state_t;

    function automatic logic signed [WW-1:0] sx(input logic signed [WD-1:0] x);
        return {{WD{x[WD-1]}}, x};
    endfunction

    // Zero divisor yields zero; quotient truncates toward zero, then to WD bits.
    function automatic logic signed [WD-1:0] qdiv(input logic signed [WW-1:0] num,
                                                  input logic signed [WW-1:0] den);
        logic signed [WW-1:0] q;
        if (den == '0) q = '0;
        else           q = num / den;
        return q[WD-1:0];
    endfunction

    state_t r_state, w_state_nxt;
    logic [KW-1:0]        r_k;
    logic signed [WD-1:0] r_p, r_g, r_r;
    logic [CH*WD-1:0]     r_u_bus, r_c_bus, r_t_bus;
    logic [CH*WD-1:0]     r_s_bus, r_l_bus;
    logic signed [WD-1:0] r_a, r_s, r_v, r_h, r_n;

    logic                 w_last;
    logic signed [WD-1:0] w_u, w_c, w_t, w_l_old;
    logic signed [WD-1:0] w_cm, w_a, w_s, w_v, w_ma, w_h, w_vs, w_y, w_o, w_n;
    logic signed [WD-1:0] w_min, w_i, w_e, w_l, w_l_new;

    assign w_last = (r_k == KW'(CH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = ST_A;
            ST_A:    w_state_nxt = ST_S;
            ST_S:    w_state_nxt = ST_D;
            ST_D:    w_state_nxt = ST_L;
            ST_L:    w_state_nxt = w_last ? DONE : ST_A;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_u     = '0;
        w_c     = '0;
        w_t     = '0;
        w_l_old = '0;
        for (int j = 0; j < CH; j++) begin
            if (r_k == KW'(j)) begin
                w_u     = r_u_bus[j*WD +: WD];
                w_c     = r_c_bus[j*WD +: WD];
                w_t     = r_t_bus[j*WD +: WD];
                w_l_old = r_l_bus[j*WD +: WD];
            end
        end
    end

    assign w_cm  = w_c - ((w_t != '0) ? ONE : '0);
    assign w_a   = w_u + w_cm * W_N;
    assign w_s   = qdiv(sx(r_a) * sx(r_p), M_W);
    assign w_v   = qdiv(sx(r_r), sx(r_g));
    assign w_ma  = M_N - r_a;
    assign w_h   = qdiv(sx(w_ma), W_W);
    assign w_vs  = r_v - r_s;
    assign w_y   = qdiv(sx(w_vs) * M_W, sx(r_p));
    assign w_o   = qdiv(sx(w_y), W_W);
    assign w_n   = w_o + ((w_o == '0) ? ONE : '0);
    assign w_min = (r_h < r_n) ? r_h : r_n;
    assign w_i   = w_min[WD-1] ? '0 : w_min;
    assign w_e   = (w_i > Q_N) ? Q_N : w_i;
    assign w_l   = (r_v >= r_s) ? w_e : '0;

`ifdef DROPOFF_SLEW_LIMIT_EN
    assign w_l_new = (w_l > w_l_old) ? (w_l_old + ONE) :
                     (w_l < w_l_old) ? (w_l_old - ONE) : w_l_old;
`else
    assign w_l_new = w_l;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k     <= '0;
            r_p     <= '0;
            r_g     <= '0;
            r_r     <= '0;
            r_u_bus <= '0;
            r_c_bus <= '0;
            r_t_bus <= '0;
            r_s_bus <= '0;
            r_l_bus <= '0;
            r_a     <= '0;
            r_s     <= '0;
            r_v     <= '0;
            r_h     <= '0;
            r_n     <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_k     <= '0;
                    r_p     <= p;
                    r_g     <= g;
                    r_r     <= r;
                    r_u_bus <= u_bus;
                    r_c_bus <= c_bus;
                    r_t_bus <= t_bus;
                end
                ST_A: r_a <= w_a;
                ST_S: begin
                    r_s <= w_s;
                    r_v <= w_v;
                end
                ST_D: begin
                    r_h <= w_h;
                    r_n <= w_n;
                end
                ST_L: begin
                    for (int j = 0; j < CH; j++) begin
                        if (r_k == KW'(j)) begin
                            r_s_bus[j*WD +: WD] <= r_s;
                            r_l_bus[j*WD +: WD] <= w_l_new;
                        end
                    end
                    if (!w_last) r_k <= r_k + KW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign s_bus     = r_s_bus;
    assign l_bus     = r_l_bus;
endmodule

// File: tb/tb_dropoff_station_scheduler.sv
// Directed-vector bench for dropoff_station_scheduler (CH=2); honours DROPOFF_SLEW_LIMIT_EN in its expectations.
module tb_dropoff_station_scheduler;
    localparam int CH = 2;
    localparam int WD = 32;

    typedef struct packed {
        logic [WD-1:0]         p, g, r;
        logic [CH-1:0][WD-1:0] u, c, t, s, l;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WD-1:0]    p = '0, g = '0, r = '0;
    logic [CH*WD-1:0] u_bus = '0, c_bus = '0, t_bus = '0;
    logic             in_ready, out_valid;
    logic [CH*WD-1:0] s_bus, l_bus;

    int n_cmp = 0;
    int n_bad = 0;
    int prev_l[CH];
    vec_t tbl[6];

    dropoff_station_scheduler #(.CH(CH), .INT(WD-1), .Q(3), .M(128000), .W(8000)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .p(p), .g(g), .r(r), .u_bus(u_bus), .c_bus(c_bus), .t_bus(t_bus),
        .s_bus(s_bus), .l_bus(l_bus), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    function automatic int slew(input int prev, input int tgt);
`ifdef DROPOFF_SLEW_LIMIT_EN
        if (tgt > prev) return prev + 1;
        if (tgt < prev) return prev - 1;
        return prev;
`else
        return tgt;
`endif
    endfunction

    task automatic set_vec(input int i, input int vp, input int vg, input int vr,
                           input int u0, input int c0, input int t0,
                           input int u1, input int c1, input int t1,
                           input int s0, input int l0, input int s1, input int l1);
        tbl[i].p = vp;  tbl[i].g = vg;  tbl[i].r = vr;
        tbl[i].u[0] = u0; tbl[i].c[0] = c0; tbl[i].t[0] = t0;
        tbl[i].u[1] = u1; tbl[i].c[1] = c1; tbl[i].t[1] = t1;
        tbl[i].s[0] = s0; tbl[i].l[0] = l0;
        tbl[i].s[1] = s1; tbl[i].l[1] = l1;
    endtask

    task automatic check_slices(input vec_t v, input string tag);
        int el;
        for (int k = 0; k < CH; k++) begin
            el = slew(prev_l[k], $signed(v.l[k]));
            prev_l[k] = el;
            check($sformatf("%s s[%0d]", tag, k), s_bus[k*WD +: WD], v.s[k]);
            check($sformatf("%s l[%0d]", tag, k), l_bus[k*WD +: WD], el);
        end
    endtask

    task automatic apply_inputs(input vec_t v);
        p = v.p; g = v.g; r = v.r;
        u_bus = v.u; c_bus = v.c; t_bus = v.t;
    endtask

    // One evaluation; inputs are scrambled after the handshake so stale capture shows up.
    task automatic do_eval(input vec_t v, input string tag);
        int n;
        @(negedge clk);
        apply_inputs(v);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        p = ~p; g = ~g; r = ~r; u_bus = ~u_bus; c_bus = ~c_bus; t_bus = ~t_bus;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, 4*CH);
        check_slices(v, tag);
        @(negedge clk);
        check({tag, " pulse end"}, {31'd0, out_valid}, 0);
        check({tag, " ready"}, {31'd0, in_ready}, 1);
    endtask

    initial begin
        vec_t v27;
        int pulses;

        //        p    g    r     u0     c0 t0   u1      c1 t1   s0   l0  s1  l1
        set_vec(0, 100, 2, 100,  32000,  1, 0,  96000,   2, 1,  31,  3, 81, 0);
        set_vec(1, 100, 2,  40,  32000,  1, 1,      0,   0, 0,  25,  0,  0, 3);
        set_vec(2, 100, 0, 100,  32000,  1, 1,      0,   1, 1,  25,  0,  0, 1);
        set_vec(3,   0, 1,   5,  32000,  1, 0, 200000,   0, 0,   0,  1,  0, 0);
        set_vec(4, 100, 4, 400,  16000,  0, 1, 120000,   1, 1,   6,  3, 93, 1);
        set_vec(5, 100, 1,   0, -16000,  1, 1,   -100,   0, 0, -12,  1,  0, 1);
        set_vec(0, 100, 2, 100,  32000,  1, 0,  96000,   2, 1,  31,  3, 81, 0);
        v27 = tbl[0];
        v27.u[1] = 32000; v27.c[1] = 1; v27.t[1] = 0; v27.s[1] = 31; v27.l[1] = 3;
        for (int k = 0; k < CH; k++) prev_l[k] = 0;

        #2;
        check("reset s_bus lo", s_bus[WD-1:0], 0);
        check("reset l_bus lo", l_bus[WD-1:0], 0);
        check("reset in_ready", {31'd0, in_ready}, 1);
        check("reset out_valid", {31'd0, out_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) do_eval(tbl[i], $sformatf("vec%0d", i));

        // Repeated identical request from a cleared l_bus: slew ramp or immediate value.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < CH; k++) prev_l[k] = 0;
        check("rst2 l_bus", l_bus[WD-1:0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) do_eval(v27, $sformatf("repeat%0d", i));

        // in_valid held high: only one handshake per evaluation, DONE before next.
        @(negedge clk);
        apply_inputs(tbl[0]);
        in_valid = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check($sformatf("busy out_valid e%0d", n), {31'd0, out_valid}, (n == 8 || n == 18) ? 1 : 0);
            check($sformatf("busy in_ready e%0d", n), {31'd0, in_ready}, (n == 9 || n == 19) ? 1 : 0);
        end
        in_valid = 1'b0;
        check_slices(tbl[0], "busy1");
        check_slices(tbl[0], "busy2");

        // Reset asserted while channel 0 sits in ST_S.
        @(negedge clk);
        apply_inputs(tbl[4]);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst s_bus lo", s_bus[WD-1:0], 0);
        check("midrst s_bus hi", s_bus[2*WD-1:WD], 0);
        check("midrst l_bus lo", l_bus[WD-1:0], 0);
        check("midrst in_ready", {31'd0, in_ready}, 1);
        check("midrst out_valid", {31'd0, out_valid}, 0);
        for (int k = 0; k < CH; k++) prev_l[k] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("midrst no pulse", pulses, 0);
        check("midrst ready after", {31'd0, in_ready}, 1);
        check("midrst l_bus hi", l_bus[2*WD-1:WD], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
